// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the dOrv32 pipeline.
// Tracks in-flight register writes from EX until they are visible in the register file.
module fwd_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int NREAD    = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid,
  input  logic                    ex_we,
  input  logic                    ex_is_load,
  input  logic [4:0]              ex_rd,
  input  logic [XLEN-1:0]         ex_data,
  input  logic                    ld_valid,
  input  logic [XLEN-1:0]         ld_data,
  input  logic [NREAD*5-1:0]      rs_addr,
  input  logic [NREAD*XLEN-1:0]   rf_data,
  output logic [NREAD*XLEN-1:0]   fwd_data,
  output logic                    stall,
  output logic [31:0]             stall_cnt,
  output logic                    ld_err
);

  typedef struct packed {
    logic            v;
    logic            rdy;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } slot_t;

  slot_t hist [1:DEPTH];   // registered history, index = age in cycles behind EX
  slot_t eff  [0:DEPTH];   // slot view seen this cycle, with returning load data applied
  logic  ld_pending;

  // Slot LOAD_LAT sees returning load data in the same cycle, so a consumer can
  // pick it up without waiting for it to be captured.
  always_comb begin
    eff[0].v    = ex_valid & ex_we & (ex_rd != 5'd0);
    eff[0].rdy  = ~ex_is_load;
    eff[0].rd   = ex_rd;
    eff[0].data = ex_data;
    for (int k = 1; k <= DEPTH; k++) eff[k] = hist[k];
    ld_pending = hist[LOAD_LAT].v & ~hist[LOAD_LAT].rdy;
    if (ld_valid && ld_pending) begin
      eff[LOAD_LAT].rdy  = 1'b1;
      eff[LOAD_LAT].data = ld_data;
    end
  end

  logic [4:0]      addr;
  logic            hit;
  logic            hit_rdy;
  logic [XLEN-1:0] hit_data;

  // NOTE: scratch variables are assigned with blocking '=' and given a default
  // before any conditional use, so this block stays purely combinational.
  always_comb begin
    stall    = 1'b0;
    fwd_data = rf_data;
    addr     = '0;
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int p = 0; p < NREAD; p++) begin
      addr     = rs_addr[p*5 +: 5];
      hit      = 1'b0;
      hit_rdy  = 1'b0;
      hit_data = '0;
      // Oldest to youngest, so the last match kept is the youngest one.
      for (int k = DEPTH; k >= 0; k--) begin
        if (eff[k].v && (eff[k].rd == addr)) begin
          hit      = 1'b1;
          hit_rdy  = eff[k].rdy;
          hit_data = eff[k].data;
        end
      end
      if ((addr != 5'd0) && hit) begin
        if (hit_rdy) fwd_data[p*XLEN +: XLEN] = hit_data;
        else         stall = 1'b1;
      end
    end
  end

  // NOTE: the history is a short shift register, not a RAM, so every slot is
  // reset; a stale valid bit after reset would raise false stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) hist[k] <= '0;
      stall_cnt <= '0;
      ld_err    <= 1'b0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) hist[k] <= eff[k-1];
      if (ld_valid && !ld_pending) ld_err <= 1'b1;
      if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, hand-written
// load/reset sequences, then randomized traffic against a queue-based model.
module tb_fwd_hazard_unit;

  localparam int XLEN     = 32;
  localparam int NREAD    = 2;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ex_valid, ex_we, ex_is_load;
  logic [4:0]            ex_rd;
  logic [XLEN-1:0]       ex_data;
  logic                  ld_valid;
  logic [XLEN-1:0]       ld_data;
  logic [NREAD*5-1:0]    rs_addr;
  logic [NREAD*XLEN-1:0] rf_data;
  logic [NREAD*XLEN-1:0] fwd_data;
  logic                  stall;
  logic [31:0]           stall_cnt;
  logic                  ld_err;

  fwd_hazard_unit #(.XLEN(XLEN), .NREAD(NREAD), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data), .ld_valid(ld_valid), .ld_data(ld_data),
    .rs_addr(rs_addr), .rf_data(rf_data), .fwd_data(fwd_data), .stall(stall),
    .stall_cnt(stall_cnt), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                       input logic [31:0] d, input logic lv, input logic [31:0] ldd,
                       input logic [4:0] r0, input logic [4:0] r1);
    ex_valid = v; ex_we = we; ex_is_load = ld; ex_rd = rd; ex_data = d;
    ld_valid = lv; ld_data = ldd; rs_addr = {r1, r0};
  endtask

  task automatic bubble(input logic [4:0] r0, input logic [4:0] r1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, r0, r1);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: one row per cycle, expectations worked out by hand.
  typedef struct {
    logic        v, we, ld;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        lv;
    logic [31:0] ldd;
    logic [4:0]  r0, r1;
    logic        st;
    logic [31:0] f0, f1;
  } vec_t;

  vec_t tbl [20];

  // Reference model: the previous DEPTH EX instructions, youngest at the front.
  typedef struct {
    bit        live;
    bit        ready;
    bit [4:0]  rd;
    bit [31:0] data;
  } wr_t;

  wr_t         past[$];
  int unsigned m_cnt;
  bit          m_err;

  function automatic wr_t age_entry(input int a);
    wr_t e;
    e = '{live: 1'b0, ready: 1'b0, rd: 5'd0, data: 32'h0};
    if (a == 0) begin
      e.live  = ex_valid && ex_we && ex_rd != 0;
      e.ready = !ex_is_load;
      e.rd    = ex_rd;
      e.data  = ex_data;
    end else if (a <= past.size()) begin
      e = past[a-1];
    end
    if (a == LOAD_LAT && ld_valid && e.live && !e.ready) begin
      e.ready = 1'b1;
      e.data  = ld_data;
    end
    return e;
  endfunction

  function automatic bit model_pending;
    if (LOAD_LAT > past.size()) return 1'b0;
    return past[LOAD_LAT-1].live && !past[LOAD_LAT-1].ready;
  endfunction

  task automatic model_eval(output bit st, output logic [31:0] f0, output logic [31:0] f1);
    logic [31:0] res [2];
    st = 1'b0;
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a;
      a      = rs_addr[p*5 +: 5];
      res[p] = rf_data[p*32 +: 32];
      if (a != 0) begin
        for (int age = 0; age <= DEPTH; age++) begin
          wr_t e;
          e = age_entry(age);
          if (e.live && e.rd == a) begin
            if (e.ready) res[p] = e.data;
            else st = 1'b1;
            break;
          end
        end
      end
    end
    f0 = res[0];
    f1 = res[1];
  endtask

  task automatic model_clock(input bit st);
    wr_t now;
    if (ld_valid) begin
      if (model_pending()) begin
        past[LOAD_LAT-1].ready = 1'b1;
        past[LOAD_LAT-1].data  = ld_data;
      end else begin
        m_err = 1'b1;
      end
    end
    if (st) m_cnt++;
    now = age_entry(0);
    if (LOAD_LAT == 0) now.ready = !ex_is_load;
    past.push_front(now);
    if (past.size() > DEPTH) void'(past.pop_back());
  endtask

  initial begin
    bit          m_st;
    logic [31:0] m_f0, m_f1;

    tbl[0]  = '{1,1,0, 5, 32'h11, 0,0, 5,0, 0, 32'h11, RF1};
    tbl[1]  = '{0,0,0, 0, 32'h0,  0,0, 5,0, 0, 32'h11, RF1};
    tbl[2]  = '{0,0,0, 0, 32'h0,  0,0, 5,0, 0, 32'h11, RF1};
    tbl[3]  = '{0,0,0, 0, 32'h0,  0,0, 5,0, 0, 32'h11, RF1};
    tbl[4]  = '{0,0,0, 0, 32'h0,  0,0, 5,0, 0, RF0,    RF1};
    tbl[5]  = '{1,1,0, 7, 32'hA,  0,0, 0,0, 0, RF0,    RF1};
    tbl[6]  = '{1,1,0, 7, 32'hB,  0,0, 0,0, 0, RF0,    RF1};
    tbl[7]  = '{0,0,0, 0, 32'h0,  0,0, 7,7, 0, 32'hB,  32'hB};
    tbl[8]  = '{1,1,0, 0, 32'hFF, 0,0, 0,7, 0, RF0,    32'hB};
    tbl[9]  = '{1,0,0, 3, 32'h33, 0,0, 3,0, 0, RF0,    RF1};
    tbl[10] = '{0,0,0, 0, 32'h0,  0,0, 3,0, 0, RF0,    RF1};
    tbl[11] = '{1,1,1, 9, 32'hDEAD, 0,0, 9,0, 1, RF0,  RF1};
    tbl[12] = '{0,0,0, 0, 32'h0,  1,32'h1234, 9,0, 0, 32'h1234, RF1};
    tbl[13] = '{0,0,0, 0, 32'h0,  0,0, 9,0, 0, 32'h1234, RF1};
    tbl[14] = '{1,1,1, 10, 32'h0, 0,0, 0,0, 0, RF0,    RF1};
    tbl[15] = '{1,1,0, 10, 32'h55, 0,0, 0,0, 0, RF0,   RF1};
    tbl[16] = '{0,0,0, 0, 32'h0,  0,0, 10,0, 0, 32'h55, RF1};
    tbl[17] = '{0,0,0, 0, 32'h0,  0,0, 10,0, 0, 32'h55, RF1};
    tbl[18] = '{0,0,0, 0, 32'h0,  0,0, 10,0, 0, 32'h55, RF1};
    tbl[19] = '{0,0,0, 0, 32'h0,  0,0, 10,0, 0, RF0,    RF1};

    rf_data = {RF1, RF0};
    bubble(5'd0, 5'd0);
    rst_n = 1'b0;
    #3;
    check("reset_stall",     {31'd0, stall},   32'd0);
    check("reset_stall_cnt", stall_cnt,        32'd0);
    check("reset_ld_err",    {31'd0, ld_err},  32'd0);
    check("reset_fwd0",      fwd_data[31:0],   RF0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].ld, tbl[i].rd, tbl[i].d, tbl[i].lv, tbl[i].ldd,
            tbl[i].r0, tbl[i].r1);
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].st});
      check($sformatf("vec%0d_fwd0", i),  fwd_data[31:0],  tbl[i].f0);
      check($sformatf("vec%0d_fwd1", i),  fwd_data[63:32], tbl[i].f1);
      next_cycle();
    end
    bubble(5'd0, 5'd0);
    check("table_stall_cnt", stall_cnt,       32'd1);
    check("table_ld_err",    {31'd0, ld_err}, 32'd0);

    // Late load: never returns, consumer stalls until the entry leaves slot DEPTH.
    drive(1'b1, 1'b1, 1'b1, 5'd12, 32'h0, 1'b0, 32'h0, 5'd12, 5'd0);
    for (int c = 0; c <= DEPTH; c++) begin
      @(negedge clk);
      check($sformatf("late_stall_age%0d", c), {31'd0, stall}, 32'd1);
      next_cycle();
      bubble(5'd12, 5'd0);
    end
    @(negedge clk);
    check("late_released",   {31'd0, stall}, 32'd0);
    check("late_fwd_rf",     fwd_data[31:0], RF0);
    check("late_stall_cnt",  stall_cnt,      32'd1 + DEPTH + 1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hCAFE, 5'd0, 5'd0);
    @(negedge clk);
    check("stray_before_edge", {31'd0, ld_err}, 32'd0);
    next_cycle();
    bubble(5'd0, 5'd0);
    check("stray_ld_err", {31'd0, ld_err}, 32'd1);
    repeat (3) next_cycle();
    check("ld_err_sticky", {31'd0, ld_err}, 32'd1);

    // Asynchronous reset in the middle of a load-use stall.
    drive(1'b1, 1'b1, 1'b1, 5'd13, 32'h0, 1'b0, 32'h0, 5'd13, 5'd0);
    next_cycle();
    bubble(5'd13, 5'd0);
    @(negedge clk);
    check("pre_reset_stall", {31'd0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_stall",     {31'd0, stall},  32'd0);
    check("async_stall_cnt", stall_cnt,       32'd0);
    check("async_ld_err",    {31'd0, ld_err}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 5'd14, 32'h0, 1'b0, 32'h0, 5'd13, 5'd14);
    #1;
    check("reset_slot0_load", {31'd0, stall}, 32'd1);
    check("reset_slot0_rf1",  fwd_data[63:32], RF1);
    drive(1'b1, 1'b1, 1'b0, 5'd15, 32'h99, 1'b0, 32'h0, 5'd13, 5'd15);
    #1;
    check("reset_slot0_alu",  fwd_data[63:32], 32'h99);
    bubble(5'd13, 5'd14);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_stall", {31'd0, stall},  32'd0);
    check("post_reset_fwd0",  fwd_data[31:0],  RF0);
    check("post_reset_fwd1",  fwd_data[63:32], RF1);

    // Randomized traffic against the model, starting from a fresh reset.
    next_cycle();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    past.delete();
    m_cnt = 0;
    m_err = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      ex_valid   = ($urandom_range(0, 9) < 8);
      ex_we      = ($urandom_range(0, 9) < 8);
      ex_is_load = ($urandom_range(0, 9) < 3);
      ex_rd      = 5'($urandom_range(0, 7));
      ex_data    = $urandom;
      ld_valid   = model_pending() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      ld_data    = $urandom;
      rs_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_data    = {$urandom, $urandom};
      @(negedge clk);
      model_eval(m_st, m_f0, m_f1);
      check("rnd_stall",     {31'd0, stall},  {31'd0, m_st});
      check("rnd_fwd0",      fwd_data[31:0],  m_f0);
      check("rnd_fwd1",      fwd_data[63:32], m_f1);
      check("rnd_stall_cnt", stall_cnt,       m_cnt);
      check("rnd_ld_err",    {31'd0, ld_err}, {31'd0, m_err});
      model_clock(m_st);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the dOrv32 pipeline. Tracks every in-flight register write from EX through the stage where the register file write becomes visible, in a registered history buffer. Delivers the youngest matching value to each ID-stage read port, and raises a stall when a consumer needs a load result that has not yet returned. Replaces the fixed two-port, single-stage bypass with configurable depth, port count and load latency, plus a stall performance counter.

## Interface
- XLEN, 32, datapath width
- NREAD, 2, number of ID-stage read ports (1..4)
- DEPTH, 3, history slots behind EX; equals cycles from EX until the register file write is readable in ID
- LOAD_LAT, 1, slot index at which load data returns (1 ≤ LOAD_LAT ≤ DEPTH)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- ex_we  in  1  instruction writes rd (0 for store/branch)
- ex_is_load  in  1  result comes from memory, not ALU
- ex_rd  in  5  destination register
- ex_data  in  XLEN  ALU result (ignored when ex_is_load)
- ld_valid  in  1  load data returning for the entry in slot LOAD_LAT
- ld_data  in  XLEN  returned load data
- rs_addr  in  NREAD*5  ID source addresses, port i at [5i+4:5i]
- rf_data  in  NREAD*XLEN  register file read data per port
- fwd_data  out  NREAD*XLEN  forwarded operand per port
- stall  out  1  hold IF/ID and inject EX bubble this cycle
- stall_cnt  out  32  cycles with stall=1 since reset
- ld_err  out  1  sticky: ld_valid arrived with no pending load in slot LOAD_LAT

## Operation
- Slot 0 is the live EX input: live when ex_valid & ex_we & ex_rd≠0. Ready iff !ex_is_load.
- Slots 1..DEPTH are registered entries {v, rd, data, rdy}. Every cycle: slot k ← slot k-1. Slot 1 ← slot 0, with v=0 if slot 0 not live. Shifting continues during stall; EX then presents a bubble.
- Load return: when ld_valid, the entry arriving in slot LOAD_LAT has its data set to ld_data and rdy set to 1.
  - If that entry is not a pending load (v=0 or rdy=1), set ld_err and leave the entry unchanged.
  - A load entry leaving slot LOAD_LAT with rdy=0 keeps rdy=0 and stalls any consumer until it exits slot DEPTH.
- Per port i, with rs_addr_i≠0, match across slots 0..DEPTH, youngest (lowest index) first:
  - Youngest match ready: fwd_data_i = its data.
  - Youngest match not ready: stall=1, fwd_data_i = rf_data_i (don't-care).
  - No match, or rs_addr_i=0: fwd_data_i = rf_data_i.
- stall = OR over ports of "youngest match not ready".
- stall_cnt increments when stall=1 and wraps at 2^32-1 → 0.
- A younger non-load write to the same rd masks an older pending load; no stall results.

## Timing
- fwd_data and stall are combinational from current inputs and registered slots, for same-cycle use in ID. No added latency.
- History, ld_err and stall_cnt update on the rising clk edge.
- Load-use distance 1 (consumer directly behind a load): stall for LOAD_LAT cycles when ld_valid arrives on time, then forward from slot LOAD_LAT+... per the match rule.
- Reset (rst_n=0, any time, asynchronous): all slot v=0, rdy=0, data=0; stall_cnt=0; ld_err=0.
  - Outputs during and after reset: stall=0 unless slot 0 is a live load matching a port; fwd_data=rf_data except slot-0 matches.
- ld_valid and a new EX write in the same cycle are independent: the slot update and the shift occur in the same edge.

## Test plan
- ALU chain: EX writes x5=0x11 (ex_we=1). Same cycle rs_addr0=5 → fwd_data0=0x11, stall=0. Next cycle (slot 1) still 0x11. After DEPTH+1 cycles, returns rf_data.
- Priority: slot 2 holds x7=0xA, slot 1 holds x7=0xB, EX bubble; rs_addr0=rs_addr1=7 → both ports 0xB.
- x0 and non-writers: EX ex_rd=0, data 0xFF; rs_addr0=0 → rf_data0. EX store (ex_we=0) to rd=3 with rs_addr=3 → rf_data, stall=0.
- Load-use (LOAD_LAT=1): EX load x9, rs_addr0=9 → stall=1, stall_cnt=1. Next cycle ld_valid, ld_data=0x1234 → stall=0, fwd_data0=0x1234 (slot 1).
- Late load: no ld_valid at slot LOAD_LAT → stall stays 1 until the entry exits DEPTH. Then stray ld_valid → ld_err=1, held until reset.
- Async reset mid-stall: pending load in slot 1, drop rst_n between edges → stall=0 and stall_cnt=0 immediately; history empty after release.
